// File: rtl/multi_word_adder_sequencer_32_bit_if.sv
// Signal bundle between the multi-word adder sequencer, its operand/result streams and the
// external 32-bit adder. Suffixes are from the sequencer's point of view.
interface multi_word_adder_sequencer_32_bit_if;
    // Control
    logic        start_i;
    logic        carry_in_i;
    logic        busy_o;
    logic        done_o;

    // Operand stream
    logic        word_valid_i;
    logic        word_ready_o;
    logic [31:0] data_a_i;
    logic [31:0] data_b_i;

    // External adder
    logic [31:0] adder_a_o;
    logic [31:0] adder_b_o;
    logic        adder_carry_o;
    logic [31:0] adder_sum_i;
    logic        adder_carry_i;

    // Result stream and status
    logic        sum_valid_o;
    logic        sum_ready_i;
    logic [31:0] sum_o;
    logic        sum_last_o;
    logic        carry_o;
    logic        overflow_o;

    modport slave (
        input  start_i,
        input  carry_in_i,
        output busy_o,
        output done_o,
        input  word_valid_i,
        output word_ready_o,
        input  data_a_i,
        input  data_b_i,
        output adder_a_o,
        output adder_b_o,
        output adder_carry_o,
        input  adder_sum_i,
        input  adder_carry_i,
        output sum_valid_o,
        input  sum_ready_i,
        output sum_o,
        output sum_last_o,
        output carry_o,
        output overflow_o
    );

    modport master (
        output start_i,
        output carry_in_i,
        input  busy_o,
        input  done_o,
        output word_valid_i,
        input  word_ready_o,
        output data_a_i,
        output data_b_i,
        input  adder_a_o,
        input  adder_b_o,
        input  adder_carry_o,
        output adder_sum_i,
        output adder_carry_i,
        input  sum_valid_o,
        output sum_ready_i,
        input  sum_o,
        input  sum_last_o,
        input  carry_o,
        input  overflow_o
    );
endinterface

// File: rtl/multi_word_adder_sequencer_32_bit.sv
// Sequences a Words x 32-bit addition, LSW first, through an external 32-bit adder and
// streams the result words out with a valid/ready handshake.
module multi_word_adder_sequencer_32_bit #(
    parameter int unsigned Words = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    multi_word_adder_sequencer_32_bit_if.slave  bus
);

    localparam int unsigned     CntW    = (Words > 1) ? $clog2(Words) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Words - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAdd,
        StOutput,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            last_word;

    assign last_word = (cnt_q == LastCnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    carry_d = bus.carry_in_i;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (bus.word_valid_i) begin
                    a_d     = bus.data_a_i;
                    b_d     = bus.data_b_i;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d   = bus.adder_sum_i;
                carry_d = bus.adder_carry_i;
                state_d = StOutput;
                // Status of the whole operation comes from the top word only.
                if (last_word) begin
                    cout_d = bus.adder_carry_i;
                    ovf_d  = (a_q[31] == b_q[31]) && (bus.adder_sum_i[31] != a_q[31]);
                end
            end
            StOutput: begin
                if (bus.sum_ready_i) begin
                    if (last_word) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Every output is a register or a decode of the state register.
    assign bus.adder_a_o     = a_q;
    assign bus.adder_b_o     = b_q;
    assign bus.adder_carry_o = carry_q;
    assign bus.sum_o         = sum_q;
    assign bus.carry_o       = cout_q;
    assign bus.overflow_o    = ovf_q;
    assign bus.word_ready_o  = (state_q == StLoad);
    assign bus.sum_valid_o   = (state_q == StOutput);
    assign bus.sum_last_o    = (state_q == StOutput) && last_word;
    assign bus.busy_o        = (state_q != StIdle);
    assign bus.done_o        = (state_q == StDone);

    stalled_result_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StOutput && !bus.sum_ready_i) |=> (state_q == StOutput && $stable(sum_q)));

    done_single_cycle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StDone) |=> (state_q == StIdle));

endmodule

// File: tb/tb_multi_word_adder_sequencer_32_bit.sv
// Self-checking bench: directed vector table, hand-written backpressure/reset sequences and a
// randomized regression against a whole-operand arithmetic model.
module tb_multi_word_adder_sequencer_32_bit;

    localparam int unsigned W  = 4;
    localparam int unsigned NB = 32 * W;

    typedef struct {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic          cin;
        logic [NB-1:0] sum;
        logic          cout;
        logic          ovf;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc_cnt = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    multi_word_adder_sequencer_32_bit_if bus ();

    multi_word_adder_sequencer_32_bit #(
        .Words (W)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    // Behavioural stand-in for the external 32-bit look-ahead adder.
    assign {bus.adder_carry_i, bus.adder_sum_i} =
        {1'b0, bus.adder_a_o} + {1'b0, bus.adder_b_o} + 33'(bus.adder_carry_o);

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic cin,
                         output logic [NB-1:0] sum, output logic cout, output logic ovf);
        logic [NB:0] full;
        full = {1'b0, a} + {1'b0, b} + (NB+1)'(cin);
        sum  = full[NB-1:0];
        cout = full[NB];
        ovf  = (a[NB-1] == b[NB-1]) && (sum[NB-1] != a[NB-1]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_word_ready"}, bus.word_ready_o, 0);
        check({tag, "_sum_valid"}, bus.sum_valid_o, 0);
        check({tag, "_sum"}, bus.sum_o, 0);
        check({tag, "_sum_last"}, bus.sum_last_o, 0);
        check({tag, "_carry"}, bus.carry_o, 0);
        check({tag, "_overflow"}, bus.overflow_o, 0);
        check({tag, "_busy"}, bus.busy_o, 0);
        check({tag, "_done"}, bus.done_o, 0);
        check({tag, "_adder_a"}, bus.adder_a_o, 0);
        check({tag, "_adder_b"}, bus.adder_b_o, 0);
        check({tag, "_adder_carry"}, bus.adder_carry_o, 0);
    endtask

    task automatic start_op(input logic cin);
        bus.start_i    = 1'b1;
        bus.carry_in_i = cin;
        tick();
        bus.start_i    = 1'b0;
        bus.carry_in_i = ~cin;
        check("start_busy", bus.busy_o, 1);
        check("start_word_ready", bus.word_ready_o, 1);
        check("start_carry_clear", bus.carry_o, 0);
        check("start_ovf_clear", bus.overflow_o, 0);
        check("start_carry_reg", bus.adder_carry_o, cin);
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] b, input int gap);
        int budget;
        bus.word_valid_i = 1'b0;
        repeat (gap) tick();
        bus.word_valid_i = 1'b1;
        bus.data_a_i     = a;
        bus.data_b_i     = b;
        budget = 50;
        while (bus.word_ready_o !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check("word_ready_wait", bus.word_ready_o, 1);
        tick();
        bus.word_valid_i = 1'b0;
        bus.data_a_i     = $urandom;
        bus.data_b_i     = $urandom;
    endtask

    task automatic recv_word(input int stall, output logic [31:0] data, output logic last);
        int budget;
        logic [31:0] hold;
        bus.sum_ready_i = 1'b0;
        budget = 50;
        while (bus.sum_valid_o !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check("sum_valid_wait", bus.sum_valid_o, 1);
        for (int i = 0; i < stall; i++) begin
            hold = bus.sum_o;
            check("stall_word_ready", bus.word_ready_o, 0);
            tick();
            check("stall_sum_hold", bus.sum_o, hold);
            check("stall_valid_hold", bus.sum_valid_o, 1);
        end
        data = bus.sum_o;
        last = bus.sum_last_o;
        bus.sum_ready_i = 1'b1;
        tick();
        bus.sum_ready_i = 1'b0;
    endtask

    task automatic finish_op(output logic cout, output logic ovf);
        check("done_pulse", bus.done_o, 1);
        cout = bus.carry_o;
        ovf  = bus.overflow_o;
        tick();
        check("done_cleared", bus.done_o, 0);
        check("busy_cleared", bus.busy_o, 0);
        check("carry_hold", bus.carry_o, cout);
        check("ovf_hold", bus.overflow_o, ovf);
    endtask

    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic cin,
                          input int gap_max, input int stall_word, input int stall_len,
                          input bit noise, output logic [NB-1:0] sum, output logic cout,
                          output logic ovf, output int cycles);
        int unsigned c0;
        logic [31:0] w;
        logic        last;
        int          stall;
        sum = '0;
        c0  = cyc_cnt;
        start_op(cin);
        for (int i = 0; i < W; i++) begin
            send_word(a[32*i +: 32], b[32*i +: 32],
                      (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
            if (noise) begin
                bus.word_valid_i = 1'b1;
            end
            stall = (i == stall_word) ? stall_len :
                    (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            recv_word(stall, w, last);
            bus.word_valid_i = 1'b0;
            sum[32*i +: 32] = w;
            check("sum_last_flag", last, (i == W - 1) ? 1 : 0);
        end
        cycles = int'(cyc_cnt - c0) + 1;
        finish_op(cout, ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          tbl [6];
        logic [NB-1:0] a, b, s, s_m;
        logic          cin, co, ov, co_m, ov_m, last;
        logic [31:0]   w;
        int            cyc;

        bus.start_i      = 1'b0;
        bus.carry_in_i   = 1'b0;
        bus.word_valid_i = 1'b0;
        bus.data_a_i     = '0;
        bus.data_b_i     = '0;
        bus.sum_ready_i  = 1'b0;

        tbl[0] = '{{W{32'hFFFF_FFFF}}, 128'h1, 1'b0, 128'h0, 1'b1, 1'b0};
        tbl[1] = '{128'h0, 128'h0, 1'b1, 128'h1, 1'b0, 1'b0};
        tbl[2] = '{128'h7FFF_FFFF_0000_0000_0000_0000_0000_0000,
                   128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0,
                   128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
        tbl[3] = '{{W{32'hFFFF_FFFF}}, {W{32'hFFFF_FFFF}}, 1'b1,
                   {W{32'hFFFF_FFFF}}, 1'b1, 1'b0};
        tbl[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000,
                   128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0,
                   128'h0, 1'b1, 1'b1};
        tbl[5] = '{128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0, 1'b1,
                   128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0};

        repeat (2) tick();
        check_zero("reset");
        rst_ni = 1'b1;
        tick();
        check_zero("idle");

        // Directed vectors with no stalls: also pins the 3*W+2 cycle latency.
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 0, -1, 0, 1'b0, s, co, ov, cyc);
            check("vec_sum", s, tbl[i].sum);
            check("vec_carry", co, tbl[i].cout);
            check("vec_ovf", ov, tbl[i].ovf);
            check("vec_cycles", cyc, 3 * W + 2);
        end

        // Five stalled cycles on word 1.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        model(a, b, 1'b0, s_m, co_m, ov_m);
        run_op(a, b, 1'b0, 0, 1, 5, 1'b0, s, co, ov, cyc);
        check("bp_sum", s, s_m);
        check("bp_carry", co, co_m);
        check("bp_ovf", ov, ov_m);

        // Start while busy, then reset after word 2 is accepted.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        model(a, b, 1'b1, s_m, co_m, ov_m);
        start_op(1'b1);
        for (int i = 0; i < 2; i++) begin
            send_word(a[32*i +: 32], b[32*i +: 32], 0);
            recv_word(0, w, last);
            check("rst_seq_word", w, s_m[32*i +: 32]);
        end
        send_word(a[64 +: 32], b[64 +: 32], 0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("busy_start_valid", bus.sum_valid_o, 1);
        check("busy_start_word2", bus.sum_o, s_m[64 +: 32]);
        check("busy_start_last", bus.sum_last_o, 0);
        rst_ni = 1'b0;
        #1;
        check_zero("mid_reset");
        #2;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset_done", bus.done_o, 0);
            check("post_reset_busy", bus.busy_o, 0);
        end
        run_op(tbl[0].a, tbl[0].b, tbl[0].cin, 0, -1, 0, 1'b0, s, co, ov, cyc);
        check("post_reset_sum", s, tbl[0].sum);
        check("post_reset_carry", co, tbl[0].cout);

        // Random regression with random gaps and stray valids outside LOAD.
        for (int n = 0; n < 20; n++) begin
            a   = {$urandom, $urandom, $urandom, $urandom};
            b   = {$urandom, $urandom, $urandom, $urandom};
            cin = 1'($urandom_range(1, 0));
            model(a, b, cin, s_m, co_m, ov_m);
            run_op(a, b, cin, 3, -1, 0, 1'b1, s, co, ov, cyc);
            check("rnd_sum", s, s_m);
            check("rnd_carry", co, co_m);
            check("rnd_ovf", ov, ov_m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_word_adder_sequencer_32_bit.md
# multi_word_adder_sequencer_32_bit

Sequential controller that performs WORDS×32-bit additions, least significant word first, on the team's combinational 32-bit look-ahead carry adder. It feeds each registered operand slice and the running carry to the adder and captures the adder's sum and carry into registers. It streams result words out with a valid/ready handshake. It sits directly upstream and downstream of the adder, and the adder is external to this block.

## Interface
- WORDS, 4, number of 32-bit words per operand; legal range 1..16.
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start_In  in  1  starts an operation; sampled only in IDLE.
- Carry_In  in  1  initial carry; sampled together with Start_In.
- Word_Valid_In  in  1  operand word pair is valid.
- Word_Ready_Out  out  1  block accepts an operand word pair.
- Data_A_In  in  32  operand A word, LSW first.
- Data_B_In  in  32  operand B word, LSW first.
- Adder_A_Out  out  32  registered A slice driven to the adder.
- Adder_B_Out  out  32  registered B slice driven to the adder.
- Adder_Carry_Out  out  1  running-carry register driven to the adder's carry input.
- Adder_Sum_In  in  32  adder sum, combinational from Adder_* outputs.
- Adder_Carry_In  in  1  adder carry output.
- Sum_Valid_Out  out  1  result word valid.
- Sum_Ready_In  in  1  downstream accepts the result word.
- Sum_Out  out  32  registered result word.
- Sum_Last_Out  out  1  high with the final result word.
- Carry_Out  out  1  final carry of the whole operation.
- Overflow_Out  out  1  signed overflow of the whole operation.
- Busy_Out  out  1  high whenever state is not IDLE.
- Done_Out  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, ADD, OUTPUT, DONE. A word counter of $clog2(WORDS) bits (minimum 1 bit) tracks the current word.
- IDLE: when Start_In=1, the carry register takes Carry_In, the counter goes to 0, Carry_Out and Overflow_Out clear, and the state moves to LOAD. Otherwise the state stays in IDLE.
- LOAD: Word_Ready_Out=1. When Word_Valid_In=1, the A and B registers take Data_A_In and Data_B_In, and the state moves to ADD.
- ADD: the A, B and carry registers drive the adder. At the end of the cycle:
  - Sum_Out takes Adder_Sum_In.
  - The carry register takes Adder_Carry_In.
  - The state moves to OUTPUT.
- ADD on the last word (counter=WORDS-1), additionally:
  - Carry_Out takes Adder_Carry_In.
  - Overflow_Out takes (A[31]==B[31]) && (Adder_Sum_In[31]!=A[31]).
- OUTPUT: Sum_Valid_Out=1, and Sum_Last_Out=1 on the last word. When Sum_Ready_In=1:
  - last word: go to DONE.
  - otherwise: increment the counter and go to LOAD.
- DONE: Done_Out=1 for one cycle, then go to IDLE.
- Carry_Out and Overflow_Out hold their values until the next accepted Start_In.
- Start_In outside IDLE is ignored.
- Word_Valid_In outside LOAD is ignored, and no word is consumed.
- Sum_Out, Sum_Last_Out and Sum_Valid_Out stay stable while Sum_Ready_In=0 (backpressure).
- Registers hold their values outside their load states.
- Adder_* outputs are driven only from registers. The block has no combinational path from any input to any output.
- WORDS=1: a single-word add; the counter never increments.

## Timing
- Reset (asynchronous assert, synchronous release): state returns to IDLE, and all outputs and registers go to 0 immediately.
- Reset mid-operation abandons the operation. Word_Ready_Out, Sum_Valid_Out and Busy_Out drop with reset assertion, and no Done_Out pulse is produced.
- Start accepted at edge N:
  - Busy_Out=1 and Word_Ready_Out=1 from cycle N+1.
  - Word accepted at edge M: Sum_Valid_Out=1 from cycle M+2.
- Throughput with no stalls: 3 cycles per word. Total for one operation: 3·WORDS+2 cycles from Start to the Done_Out pulse.
- Done_Out is high in the cycle after the last Sum handshake. Busy_Out is low in the following cycle.
- Start_In is accepted again in the first IDLE cycle, which is the cycle after DONE.
- The adder's combinational delay must fit within a single ADD cycle; the block does not multicycle that path.

## Test plan
- Carry ripple across all words:
  - Stimulus: WORDS=4, Cin=0, A words all 0xFFFFFFFF, B words {0x00000001, 0, 0, 0}.
  - Required: Sum words 0, 0, 0, 0 with Sum_Last_Out on word 3; Carry_Out=1; Overflow_Out=0; Done_Out one cycle after the last handshake.
- Initial carry only:
  - Stimulus: Cin=1, A and B all zero.
  - Required: Sum words {1, 0, 0, 0}; Carry_Out=0.
- Signed overflow on the top word:
  - Stimulus: lower words 0; top word A=0x7FFFFFFF, B=0x00000001.
  - Required: last Sum=0x80000000; Overflow_Out=1; Carry_Out=0.
- Backpressure:
  - Stimulus: hold Sum_Ready_In=0 for 5 cycles on word 1.
  - Required: Sum_Out and Sum_Valid_Out stable; Word_Ready_Out=0 throughout; the result is still correct.
- Start while busy, then reset mid-operation:
  - Stimulus: pulse Start_In during word 2, then pulse Reset_n low after word 2 is accepted.
  - Required: the extra Start has no effect. After reset, all outputs are 0, state is IDLE, and no Done_Out pulse occurs. The next operation yields the correct sum.
- Random regression:
  - Stimulus: 20 random 128-bit operations with the team's 32-bit look-ahead carry adder attached, and random valid/ready gaps.
  - Required: each result matches (A+B+Cin) mod 2^128, plus the correct carry and overflow.
